// File: rtl/pht_update_scheduler_pkg.sv
// Shared types and constants for the PHT update scheduler slice.
package pht_update_scheduler_pkg;

   localparam int ENTRY_NUM     = 2048;
   localparam int INDEX_WIDTH   = $clog2(ENTRY_NUM);
   localparam int COUNTER_WIDTH = 2;
   localparam int QUEUE_DEPTH   = 4;
   localparam int INIT_VALUE    = 1;
   localparam int QPTR_W        = $clog2(QUEUE_DEPTH);
   localparam int QCNT_W        = QPTR_W + 1;

   typedef logic [INDEX_WIDTH-1:0]   PHT_IndexPath;
   typedef logic [COUNTER_WIDTH-1:0] PHT_CounterPath;
   typedef logic [QPTR_W-1:0]        PHT_QueuePtr;
   typedef logic [QCNT_W-1:0]        PHT_QueueCnt;

   typedef struct packed {
      PHT_IndexPath   index;
      PHT_CounterPath value;
   } PHT_UpdateEntry;

   typedef enum logic {
      PHT_SCHED_INIT,
      PHT_SCHED_RUN
   } PHT_SchedState;

   localparam PHT_CounterPath CTR_MAX = '1;

   // Saturating counter step; never wraps in either direction.
   function automatic PHT_CounterPath pht_step(input PHT_CounterPath c, input logic taken);
      if (taken) return (c == CTR_MAX) ? c : c + PHT_CounterPath'(1);
      else       return (c == '0) ? c : c - PHT_CounterPath'(1);
   endfunction

endpackage

// File: rtl/pht_update_scheduler_if.sv
// Branch-resolution update channel from the backend to the scheduler.
interface pht_update_scheduler_if;
   import pht_update_scheduler_pkg::*;

   logic           upd_valid;
   PHT_IndexPath   upd_index;
   logic           upd_taken;
   PHT_CounterPath upd_prev_ctr;
   logic           upd_ready;

   modport master (output upd_valid, output upd_index, output upd_taken,
                   output upd_prev_ctr, input upd_ready);
   modport slave  (input upd_valid, input upd_index, input upd_taken,
                   input upd_prev_ctr, output upd_ready);
endinterface

// File: rtl/pht_update_scheduler_queue.sv
// Small FIFO of pending PHT updates with a parallel index lookup so that a
// new update to an already-queued index can be merged in place.
module pht_update_queue
   import pht_update_scheduler_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           clr_i,
   input  logic           push_i,
   input  PHT_UpdateEntry push_entry_i,
   input  logic           pop_i,
   input  logic           mod_en_i,
   input  PHT_QueuePtr    mod_ptr_i,
   input  PHT_CounterPath mod_value_i,
   input  PHT_IndexPath   cmp_index_i,
   output logic           hit_o,
   output PHT_QueuePtr    hit_ptr_o,
   output PHT_CounterPath hit_value_o,
   output PHT_UpdateEntry head_o,
   output PHT_QueuePtr    head_ptr_o,
   output logic           empty_o,
   output logic           full_o
);

   PHT_UpdateEntry entry_q [QUEUE_DEPTH];
   PHT_QueuePtr    head_q;
   PHT_QueuePtr    tail_q;
   PHT_QueueCnt    cnt_q;
   PHT_QueuePtr    rel;

   assign empty_o    = (cnt_q == '0);
   assign full_o     = (cnt_q == PHT_QueueCnt'(QUEUE_DEPTH));
   assign head_o     = entry_q[head_q];
   assign head_ptr_o = head_q;

   // Compare the incoming index against every live slot; at most one can match.
   always_comb begin
      hit_o       = 1'b0;
      hit_ptr_o   = '0;
      hit_value_o = '0;
      rel         = '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         rel = PHT_QueuePtr'(i) - head_q;
         if (({1'b0, rel} < cnt_q) && (entry_q[i].index == cmp_index_i)) begin
            hit_o       = 1'b1;
            hit_ptr_o   = PHT_QueuePtr'(i);
            hit_value_o = entry_q[i].value;
         end
      end
   end

   // Pointer and occupancy bookkeeping; clear drops everything at once.
   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push_i) tail_q <= tail_q + PHT_QueuePtr'(1);
         if (pop_i)  head_q <= head_q + PHT_QueuePtr'(1);
         case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + PHT_QueueCnt'(1);
            2'b01:   cnt_q <= cnt_q - PHT_QueueCnt'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Slot storage needs no reset; liveness comes from the pointers.
   always_ff @(posedge clk) begin
      if (push_i)   entry_q[tail_q]         <= push_entry_i;
      if (mod_en_i) entry_q[mod_ptr_i].value <= mod_value_i;
   end

endmodule

// File: rtl/pht_update_scheduler.sv
// Owns the PHT write port: table init, update buffering/merging, and
// arbitration of the port against fetch-side prediction reads.
//
//   state          | meaning
//   PHT_SCHED_INIT | writing INIT_VALUE to every entry, one per cycle
//   PHT_SCHED_RUN  | table valid; draining queued updates vs. fetch reads
module pht_update_scheduler
   import pht_update_scheduler_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   pht_update_scheduler_if.slave  upd,
   input  logic                   flush_req_i,
   input  logic                   pred_rd_req_i,
   output logic                   pred_rd_grant_o,
   output logic                   pht_we_o,
   output PHT_IndexPath           pht_waddr_o,
   output PHT_CounterPath         pht_wdata_o,
   output logic                   init_done_o
);

   PHT_SchedState  state_q;
   PHT_IndexPath   init_idx_q;

   logic           q_hit, q_empty, q_full;
   PHT_QueuePtr    q_hit_ptr, q_head_ptr;
   PHT_CounterPath q_hit_value;
   PHT_UpdateEntry q_head;

   logic           run, ready, accept, wr_sel, deq, bypass, mod_en, push;
   PHT_CounterPath merged_value;
   PHT_UpdateEntry new_entry;

   assign run    = !rst && (state_q == PHT_SCHED_RUN);
   assign ready  = run && !q_full && !flush_req_i;
   assign accept = upd.upd_valid && ready;

   // A full queue takes the port regardless of fetch so updates cannot starve.
   assign wr_sel = !q_empty && (!pred_rd_req_i || q_full);
   assign deq    = run && wr_sel && !flush_req_i;

   assign merged_value = pht_step(q_hit_value, upd.upd_taken);
   assign bypass       = accept && q_hit && deq && (q_hit_ptr == q_head_ptr);
   assign mod_en       = accept && q_hit && !bypass;
   assign push         = accept && !q_hit;
   assign new_entry    = '{index: upd.upd_index,
                           value: pht_step(upd.upd_prev_ctr, upd.upd_taken)};

   assign upd.upd_ready = ready;

   pht_update_queue u_queue (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (flush_req_i),
      .push_i       (push),
      .push_entry_i (new_entry),
      .pop_i        (deq),
      .mod_en_i     (mod_en),
      .mod_ptr_i    (q_hit_ptr),
      .mod_value_i  (merged_value),
      .cmp_index_i  (upd.upd_index),
      .hit_o        (q_hit),
      .hit_ptr_o    (q_hit_ptr),
      .hit_value_o  (q_hit_value),
      .head_o       (q_head),
      .head_ptr_o   (q_head_ptr),
      .empty_o      (q_empty),
      .full_o       (q_full)
   );

   // Sequencing FSM with the init address counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= PHT_SCHED_INIT;
         init_idx_q <= '0;
      end else begin
         case (state_q)
            PHT_SCHED_INIT: begin
               if (flush_req_i) begin
                  init_idx_q <= '0;
               end else if (init_idx_q == PHT_IndexPath'(ENTRY_NUM-1)) begin
                  init_idx_q <= '0;
                  state_q    <= PHT_SCHED_RUN;
               end else begin
                  init_idx_q <= init_idx_q + PHT_IndexPath'(1);
               end
            end
            default: begin
               if (flush_req_i) begin
                  init_idx_q <= '0;
                  state_q    <= PHT_SCHED_INIT;
               end
            end
         endcase
      end
   end

   // Port driver; head data is bypassed with a same-cycle merge into it.
   always_comb begin
      pht_we_o        = 1'b0;
      pht_waddr_o     = '0;
      pht_wdata_o     = '0;
      pred_rd_grant_o = 1'b0;
      init_done_o     = 1'b0;
      if (!rst) begin
         if (state_q == PHT_SCHED_INIT) begin
            pht_we_o    = 1'b1;
            pht_waddr_o = init_idx_q;
            pht_wdata_o = PHT_CounterPath'(INIT_VALUE);
         end else begin
            init_done_o     = 1'b1;
            pred_rd_grant_o = pred_rd_req_i && !wr_sel;
            if (deq) begin
               pht_we_o    = 1'b1;
               pht_waddr_o = q_head.index;
               pht_wdata_o = bypass ? merged_value : q_head.value;
            end
         end
      end
   end

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Directed bench with a write scoreboard: stimulus queues expected PHT
// writes, a negedge monitor pops and compares every observed write.
module tb_pht_update_scheduler;
   import pht_update_scheduler_pkg::*;

   logic           clk = 1'b0;
   logic           rst;
   logic           flush_req, pred_rd_req, pred_rd_grant;
   logic           pht_we, init_done;
   PHT_IndexPath   pht_waddr;
   PHT_CounterPath pht_wdata;

   int checks   = 0;
   int failures = 0;
   int exp_addr_q[$];
   int exp_data_q[$];

   pht_update_scheduler_if u_if ();

   pht_update_scheduler dut (
      .clk             (clk),
      .rst             (rst),
      .upd             (u_if.slave),
      .flush_req_i     (flush_req),
      .pred_rd_req_i   (pred_rd_req),
      .pred_rd_grant_o (pred_rd_grant),
      .pht_we_o        (pht_we),
      .pht_waddr_o     (pht_waddr),
      .pht_wdata_o     (pht_wdata),
      .init_done_o     (init_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic nc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input int idx, input logic t, input int prev);
      u_if.upd_valid    = v;
      u_if.upd_index    = PHT_IndexPath'(idx);
      u_if.upd_taken    = t;
      u_if.upd_prev_ctr = PHT_CounterPath'(prev);
   endtask

   task automatic expect_wr(input int addr, input int data);
      exp_addr_q.push_back(addr);
      exp_data_q.push_back(data);
   endtask

   // Monitor: every observed write must match the next expected one.
   always @(negedge clk) begin
      if (pht_we) begin
         checks++;
         if (exp_addr_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write addr=%0d data=%0d", pht_waddr, pht_wdata);
         end else begin
            int ea, ed;
            ea = exp_addr_q.pop_front();
            ed = exp_data_q.pop_front();
            if (int'(pht_waddr) != ea || int'(pht_wdata) != ed) begin
               failures++;
               $display("FAIL pht_write actual=%0d/%0d expected=%0d/%0d",
                        pht_waddr, pht_wdata, ea, ed);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; flush_req = 1'b0; pred_rd_req = 1'b0;
      drive(1'b0, 0, 1'b0, 0);
      repeat (2) @(posedge clk);
      #1;
      // Reset holds every output low even with requests pending.
      pred_rd_req = 1'b1;
      drive(1'b1, 7, 1'b1, 1);
      @(negedge clk);
      chk("rst_we", pht_we, 0);
      chk("rst_grant", pred_rd_grant, 0);
      chk("rst_ready", u_if.upd_ready, 0);
      chk("rst_init_done", init_done, 0);
      for (int i = 0; i < ENTRY_NUM; i++) expect_wr(i, 1);
      nc();
      rst = 1'b0;
      drive(1'b0, 0, 1'b0, 0);
      for (int i = 0; i < ENTRY_NUM; i++) begin
         @(negedge clk);
         chk("init_grant", pred_rd_grant, 0);
         if (i == 0 || i == ENTRY_NUM-1) chk("init_not_done", init_done, 0);
         if (i == 0) chk("init_ready", u_if.upd_ready, 0);
         nc();
      end
      @(negedge clk);
      chk("init_done", init_done, 1);
      chk("run_grant", pred_rd_grant, 1);

      // Saturation and latency.
      nc(); pred_rd_req = 1'b0;
      drive(1'b1, 10, 1'b1, 3); expect_wr(10, 3);
      @(negedge clk);
      chk("sat_ready", u_if.upd_ready, 1);
      chk("latency_we", pht_we, 0);
      nc(); drive(1'b1, 11, 1'b0, 0); expect_wr(11, 0);
      nc(); drive(1'b1, 12, 1'b1, 1); expect_wr(12, 2);
      nc(); drive(1'b0, 0, 1'b0, 0);
      nc(); nc();

      // Merge while fetch holds the port.
      pred_rd_req = 1'b1;
      drive(1'b1, 5, 1'b1, 1);
      @(negedge clk);
      chk("merge_ready", u_if.upd_ready, 1);
      nc(); drive(1'b1, 5, 1'b1, 0);
      nc(); drive(1'b0, 0, 1'b0, 0);
      @(negedge clk);
      chk("merge_hold_we", pht_we, 0);
      chk("merge_hold_grant", pred_rd_grant, 1);
      nc(); pred_rd_req = 1'b0; expect_wr(5, 3);
      @(negedge clk);
      chk("merge_we", pht_we, 1);
      nc();
      @(negedge clk);
      chk("merge_single", pht_we, 0);

      // Full queue wins arbitration.
      nc(); pred_rd_req = 1'b1;
      for (int k = 0; k < QUEUE_DEPTH; k++) begin
         drive(1'b1, 20 + k, 1'b1, 0); expect_wr(20 + k, 1);
         @(negedge clk);
         chk("fill_ready", u_if.upd_ready, 1);
         nc();
      end
      drive(1'b0, 0, 1'b0, 0);
      @(negedge clk);
      chk("full_ready", u_if.upd_ready, 0);
      chk("full_we", pht_we, 1);
      chk("full_grant", pred_rd_grant, 0);
      nc();
      @(negedge clk);
      chk("after_full_we", pht_we, 0);
      chk("after_full_grant", pred_rd_grant, 1);
      nc(); pred_rd_req = 1'b0;
      nc(); nc(); nc();
      @(negedge clk);
      chk("drained_we", pht_we, 0);

      // Same-cycle merge into the head being written.
      nc(); pred_rd_req = 1'b1;
      drive(1'b1, 9, 1'b1, 1);
      nc(); pred_rd_req = 1'b0;
      drive(1'b1, 9, 1'b1, 0); expect_wr(9, 3);
      @(negedge clk);
      chk("bypass_we", pht_we, 1);
      chk("bypass_ready", u_if.upd_ready, 1);
      nc(); drive(1'b0, 0, 1'b0, 0);
      @(negedge clk);
      chk("bypass_empty", pht_we, 0);

      // Flush discards the queue and restarts init.
      nc(); pred_rd_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 30 + k, 1'b1, 2);
         nc();
      end
      flush_req = 1'b1; pred_rd_req = 1'b0;
      drive(1'b1, 40, 1'b1, 1);
      for (int i = 0; i < ENTRY_NUM; i++) expect_wr(i, 1);
      @(negedge clk);
      chk("flush_we", pht_we, 0);
      chk("flush_ready", u_if.upd_ready, 0);
      nc(); flush_req = 1'b0; drive(1'b0, 0, 1'b0, 0);
      for (int i = 0; i < ENTRY_NUM; i++) begin
         if (i == 0) begin
            @(negedge clk);
            chk("reinit_not_done", init_done, 0);
         end
         nc();
      end
      @(negedge clk);
      chk("reinit_done", init_done, 1);
      chk("reinit_queue_empty", pht_we, 0);
      nc(); nc();
      chk("sb_drained", exp_addr_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
